// File: rtl/latency_meter_pkg.sv
// Shared types for the round-trip latency meter: FSM states and the BCD digit type.
package latency_meter_pkg;

    typedef enum logic [1:0] {IDLE, ARMING, RECEIVING, PAUSING} state_e;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_NINE = 4'd9;

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit of the latency counter; chains through carry_in/carry_out and holds when saturated.
module bcd_digit_counter
    import latency_meter_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic carry_in,
    input  logic saturate,
    output bcd_t digit,
    output logic carry_out
);

    bcd_t digit_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            digit_q <= '0;
        end else if (clear) begin
            digit_q <= '0;
        end else if (carry_in && !saturate) begin
            digit_q <= (digit_q == BCD_NINE) ? '0 : digit_q + 4'd1;
        end
    end

    assign carry_out = carry_in && (digit_q == BCD_NINE);
    assign digit     = digit_q;

endmodule

// File: rtl/debouncer.sv
// Level debouncer: the output follows the synchronised input once it has differed for PERIOD cycles.
module debouncer #(
    parameter int unsigned PERIOD = 10_000
) (
    input  logic clk,
    input  logic resetn,
    input  logic noisy,
    output logic debounce,
    output logic debouncing
);

    localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);

    logic          in_sync;
    logic          out_q;
    logic [CW-1:0] cnt_q;

    synchronizer #(
        .STAGES(2)
    ) u_sync (
        .clk   (clk),
        .resetn(resetn),
        .d     (noisy),
        .q     (in_sync)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_q <= 1'b0;
            cnt_q <= '0;
        end else if (in_sync == out_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            out_q <= in_sync;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign debounce   = out_q;
    assign debouncing = (in_sync != out_q);

endmodule

// File: rtl/seven_decimal.sv
// BCD to seven-segment decoder, seg[6:0] = gfedcba active high, seg[7] = decimal point.
module seven_decimal
    import latency_meter_pkg::*;
(
    input  bcd_t       digit,
    input  logic       point,
    output logic [7:0] seg
);

    always_comb begin
        seg[7] = point;
        case (digit)
            4'd0:    seg[6:0] = 7'h3F;
            4'd1:    seg[6:0] = 7'h06;
            4'd2:    seg[6:0] = 7'h5B;
            4'd3:    seg[6:0] = 7'h4F;
            4'd4:    seg[6:0] = 7'h66;
            4'd5:    seg[6:0] = 7'h6D;
            4'd6:    seg[6:0] = 7'h7D;
            4'd7:    seg[6:0] = 7'h07;
            4'd8:    seg[6:0] = 7'h7F;
            4'd9:    seg[6:0] = 7'h6F;
            default: seg[6:0] = 7'h00;
        endcase
    end

endmodule

// File: rtl/synchronizer.sv
// Multi-flop synchronizer for an asynchronous single-bit input; STAGES must be at least 2.
module synchronizer #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/latency_meter.sv
// Round-trip latency meter: times send-to-receive in BCD ticks and shows it on seven-segment codes.
// Define LATENCY_METER_MAX_HOLD_EN to display the running maximum of non-overflow results instead.
module latency_meter
    import latency_meter_pkg::*;
#(
    parameter int unsigned DIGITS          = 4,
    parameter int unsigned TICK_CYCLES     = 10_000,
    parameter int unsigned PAUSE_CYCLES    = 10_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 10_000,
    parameter int unsigned POINT_DIGIT     = 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                run,
    input  logic                start,
    input  logic                send,
    input  logic                receive,
    output logic                enable,
    output logic                busy,
    output logic                valid,
    output logic                overflow,
    output logic [8*DIGITS-1:0] segments
);

    localparam int unsigned TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int unsigned PW = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_CYCLES - 1);
    localparam logic [PW-1:0] PAUSE_LAST = PW'(PAUSE_CYCLES - 1);

    state_e state_q, state_d;

    logic send_sync;
    logic rx_deb;
    logic rx_debouncing;

    logic [TW-1:0] tick_q;
    logic [PW-1:0] pause_q;
    logic          tick_wrap;

    logic arm_go;
    logic tick_run;
    logic count_en;
    logic latch_result;
    logic latch_overflow;

    bcd_t                digit_val [DIGITS];
    logic [DIGITS:0]     carry;
    logic [4*DIGITS-1:0] digits_flat;
    logic [4*DIGITS-1:0] result_bcd;

    logic [4*DIGITS-1:0] disp_q;
    logic                disp_on_q;
    logic                valid_q;
    logic                overflow_q;
    logic [8*DIGITS-1:0] seg_raw;

    synchronizer #(
        .STAGES(2)
    ) u_send_sync (
        .clk   (clk),
        .resetn(resetn),
        .d     (send),
        .q     (send_sync)
    );

    debouncer #(
        .PERIOD(DEBOUNCE_CYCLES)
    ) u_rx_debounce (
        .clk       (clk),
        .resetn    (resetn),
        .noisy     (receive),
        .debounce  (rx_deb),
        .debouncing(rx_debouncing)
    );

    // Digit 0 is stepped on each tick wrap; a carry out of the top digit means all digits are 9.
    assign tick_wrap = (tick_q == TICK_LAST);
    assign count_en  = (state_q == RECEIVING) && !rx_deb && tick_wrap;
    assign carry[0]  = count_en;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit_counter u_digit (
            .clk      (clk),
            .resetn   (resetn),
            .clear    (arm_go),
            .carry_in (carry[i]),
            .saturate (carry[DIGITS]),
            .digit    (digit_val[i]),
            .carry_out(carry[i+1])
        );

        assign digits_flat[4*i +: 4] = digit_val[i];

        seven_decimal u_seg (
            .digit(disp_q[4*i +: 4]),
            .point(i == POINT_DIGIT),
            .seg  (seg_raw[8*i +: 8])
        );
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (start) state_d = ARMING;
            ARMING:    if (arm_go) state_d = RECEIVING;
            RECEIVING: if (latch_result || latch_overflow) state_d = PAUSING;
            PAUSING:   if (pause_q == PAUSE_LAST) state_d = run ? ARMING : IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        enable         = 1'b0;
        busy           = (state_q != IDLE);
        arm_go         = 1'b0;
        tick_run       = 1'b0;
        latch_result   = 1'b0;
        latch_overflow = 1'b0;
        unique case (state_q)
            IDLE: ;
            ARMING: begin
                // Never arm while a previous receive is still high or settling.
                if (!(rx_deb || rx_debouncing)) begin
                    enable = 1'b1;
                    arm_go = send_sync;
                end
            end
            RECEIVING: begin
                if (rx_deb) begin
                    latch_result = 1'b1;
                end else begin
                    tick_run       = 1'b1;
                    latch_overflow = carry[DIGITS];
                    enable         = !carry[DIGITS];
                end
            end
            PAUSING: ;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tick_q <= '0;
        end else if (arm_go) begin
            tick_q <= '0;
        end else if (tick_run) begin
            tick_q <= tick_wrap ? '0 : tick_q + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pause_q <= '0;
        end else if (state_q != PAUSING) begin
            pause_q <= '0;
        end else if (pause_q != PAUSE_LAST) begin
            pause_q <= pause_q + PW'(1);
        end
    end

`ifdef LATENCY_METER_MAX_HOLD_EN
    logic [4*DIGITS-1:0] max_q;

    // Packed BCD with the MSD on top compares correctly as a plain unsigned vector.
    assign result_bcd = (digits_flat > max_q) ? digits_flat : max_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            max_q <= '0;
        end else if (latch_result) begin
            max_q <= result_bcd;
        end
    end
`else
    assign result_bcd = digits_flat;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            disp_on_q  <= 1'b0;
            disp_q     <= '0;
        end else begin
            valid_q <= latch_result || latch_overflow;
            if (latch_result) begin
                disp_q     <= result_bcd;
                disp_on_q  <= 1'b1;
                overflow_q <= 1'b0;
            end else if (latch_overflow) begin
                disp_q     <= digits_flat;
                disp_on_q  <= 1'b1;
                overflow_q <= 1'b1;
            end
        end
    end

    assign valid    = valid_q;
    assign overflow = overflow_q;
    assign segments = disp_on_q ? seg_raw : '0;

endmodule
